// File: rtl/keypad_scanner.sv
// keypad_scanner -- 4x4 matrix keypad scanner with debounce and ghost rejection.
//
// Walks a single active-low row drive across R0..R3, samples the synchronized
// column sense after a settle period, debounces a single-key press, reports it
// once, and then holds the row until the key has been released for DEBOUNCE
// consecutive samples.
//
// Parameters
//   SETTLE   : cycles each row is driven before its columns are sampled (3..255)
//   DEBOUNCE : consecutive matching samples needed to accept a press/release (1..255)
//
// Ports
//   clk_i       : system clock, rising edge
//   rst_i       : synchronous active-high reset
//   col_i       : column sense {C3,C2,C1,C0}, active-low, asynchronous
//   row_o       : row drive {R3,R2,R1,R0}, active-low, exactly one bit low
//   key_o       : code of the last accepted key, held between presses
//   key_valid_o : one-cycle pulse when a new key is accepted
//   key_held_o  : high while the accepted key remains pressed
module keypad_scanner #(
   parameter int unsigned SETTLE   = 4,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] col_i,
   output logic [3:0] row_o,
   output logic [3:0] key_o,
   output logic       key_valid_o,
   output logic       key_held_o
);

   typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_e;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [7:0] DEB_LAST    = 8'(DEBOUNCE - 1);

   state_e     state_q, state_d;
   logic [1:0] r_q, r_d;
   logic [1:0] cidx_q, cidx_d;
   logic [3:0] lcol_q, lcol_d;
   logic [7:0] settle_q, settle_d;
   logic [7:0] match_q, match_d;
   logic [7:0] rel_q, rel_d;
   logic [3:0] key_q, key_d;
   logic       valid_q, valid_d;
   logic [3:0] sync1_q, scol_q;

   logic [3:0] low;
   logic       one_low;
   logic [1:0] cidx_enc;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
         4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
         4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
         4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
      endcase
      return code;
   endfunction

   // Exactly one column pulled low; two or more low is a ghost/multi-press.
   assign low     = ~scol_q;
   assign one_low = (low != 4'h0) && ((low & (low - 4'd1)) == 4'h0);

   always_comb begin
      if      (!scol_q[0]) cidx_enc = 2'd0;
      else if (!scol_q[1]) cidx_enc = 2'd1;
      else if (!scol_q[2]) cidx_enc = 2'd2;
      else                 cidx_enc = 2'd3;
   end

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      cidx_d   = cidx_q;
      lcol_d   = lcol_q;
      settle_d = settle_q;
      match_d  = match_q;
      rel_d    = rel_q;
      key_d    = key_q;
      valid_d  = 1'b0;
      case (state_q)
         ST_SCAN: begin
            if (settle_q >= SETTLE_LAST) begin
               settle_d = 8'd0;
               if (one_low) begin
                  lcol_d  = scol_q;
                  cidx_d  = cidx_enc;
                  match_d = 8'd0;
                  state_d = ST_DEBOUNCE;
               end else begin
                  r_d = r_q + 2'd1;
               end
            end else begin
               settle_d = sat_inc(settle_q);
            end
         end
         ST_DEBOUNCE: begin
            if (scol_q == lcol_q) begin
               // This matching sample is the DEBOUNCE-th one: accept the key.
               if (match_q >= DEB_LAST) begin
                  key_d   = keymap(r_q, cidx_q);
                  valid_d = 1'b1;
                  match_d = 8'd0;
                  rel_d   = 8'd0;
                  state_d = ST_HELD;
               end else begin
                  match_d = sat_inc(match_q);
               end
            end else begin
               match_d  = 8'd0;
               settle_d = 8'd0;
               r_d      = r_q + 2'd1;
               state_d  = ST_SCAN;
            end
         end
         ST_HELD: begin
            if (scol_q == 4'hF) begin
               if (rel_q >= DEB_LAST) begin
                  rel_d    = 8'd0;
                  settle_d = 8'd0;
                  r_d      = r_q + 2'd1;
                  state_d  = ST_SCAN;
               end else begin
                  rel_d = sat_inc(rel_q);
               end
            end else begin
               rel_d = 8'd0;
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_SCAN;
         r_q      <= 2'd0;
         cidx_q   <= 2'd0;
         lcol_q   <= 4'hF;
         settle_q <= 8'd0;
         match_q  <= 8'd0;
         rel_q    <= 8'd0;
         key_q    <= 4'h0;
         valid_q  <= 1'b0;
         sync1_q  <= 4'hF;
         scol_q   <= 4'hF;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         cidx_q   <= cidx_d;
         lcol_q   <= lcol_d;
         settle_q <= settle_d;
         match_q  <= match_d;
         rel_q    <= rel_d;
         key_q    <= key_d;
         valid_q  <= valid_d;
         sync1_q  <= col_i;
         scol_q   <= sync1_q;
      end
   end

   assign row_o       = ~(4'b0001 << r_q);
   assign key_o       = key_q;
   assign key_valid_o = valid_q;
   assign key_held_o  = (state_q == ST_HELD);

endmodule
